// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcode encoding, the
// scheduler FSM states and the bit positions inside the response flag nibble.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5
  } alu_op_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } sched_state_e;

  // rsp_flags = {err, cout, ovf, zero}
  localparam int unsigned FlagZero = 0;
  localparam int unsigned FlagOvf  = 1;
  localparam int unsigned FlagCout = 2;
  localparam int unsigned FlagErr  = 3;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Bundle of the scheduler's request, ALU and response signals.
//   slave  : the scheduler side (accepts requests, drives the ALU, returns responses)
//   master : the environment side (requesters, the ALU datapath, response consumer)
interface alu_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;

  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [3:0]            alu_opcode;
  logic [31:0]           alu_result;
  logic                  alu_zero;
  logic                  alu_ovf;
  logic                  alu_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [3:0]            rsp_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_result, alu_zero, alu_ovf, alu_cout,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_result, alu_zero, alu_ovf, alu_cout,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   ptr      : highest-priority index for this arbitration
//   grant    : one-hot grant (all-zero when no request)
//   grant_id : binary index of the granted requester
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int unsigned     idx;
  logic [ID_W-1:0] idx_w;
  logic            found;

  // Scan upward from ptr, wrapping at NUM_REQ-1; the first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration. An accepted operation is issued from registered operands one cycle
// later; the result and flags are captured and returned tagged with the requester id.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : request / ALU / response signals (slave side)
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_rr_scheduler_if.slave   bus_io
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  sched_state_e        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [3:0]          op_q, op_d;
  logic                err_q, err_d;
  logic [31:0]         result_q, result_d;
  logic [3:0]          flags_q, flags_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [31:0]         sel_a, sel_b;
  logic [3:0]          sel_op;
  logic                sel_legal;
  logic                accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req      (bus_io.req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_a     = bus_io.req_a[{grant_id, 5'd0} +: 32];
  assign sel_b     = bus_io.req_b[{grant_id, 5'd0} +: 32];
  assign sel_op    = bus_io.req_op[{grant_id, 2'd0} +: 4];
  assign sel_legal = op_is_legal(sel_op);

  // rst_n gating keeps req_ready low while reset is held, since state_q reads IDLE then.
  assign bus_io.req_ready = (state_q == StIdle && rst_n) ? grant : '0;
  assign accept           = |(bus_io.req_valid & bus_io.req_ready);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    err_d    = err_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // Illegal opcodes are squashed to ADD 0,0 so the ALU sees benign inputs.
          a_d      = sel_legal ? sel_a : '0;
          b_d      = sel_legal ? sel_b : '0;
          op_d     = sel_legal ? sel_op : '0;
          err_d    = ~sel_legal;
          id_d     = grant_id;
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        result_d           = err_q ? '0 : bus_io.alu_result;
        flags_d            = '0;
        flags_d[FlagErr]   = err_q;
        flags_d[FlagCout]  = ~err_q & bus_io.alu_cout;
        flags_d[FlagOvf]   = ~err_q & bus_io.alu_ovf;
        flags_d[FlagZero]  = ~err_q & bus_io.alu_zero;
        state_d            = StResp;
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      err_q    <= err_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // ALU inputs come straight from the operand registers, so they hold between operations.
  assign bus_io.alu_a      = a_q;
  assign bus_io.alu_b      = b_q;
  assign bus_io.alu_opcode = op_q;

  assign bus_io.rsp_valid  = (state_q == StResp);
  assign bus_io.rsp_id     = id_q;
  assign bus_io.rsp_result = result_q;
  assign bus_io.rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler with a behavioural 32-bit ALU attached.
// SUB reports cout as borrow (a < b).
module tb_alu_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;

  logic clk;
  logic rst_n;

  alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  alu_rr_scheduler #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  logic [32:0] m_sum;
  logic [31:0] m_res;
  logic        m_cout, m_ovf;

  always_comb begin
    m_sum  = '0;
    m_res  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    case (bus.alu_opcode)
      4'd0: begin
        m_sum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_res  = m_sum[31:0];
        m_cout = m_sum[32];
        m_ovf  = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
      4'd1: begin
        m_res  = bus.alu_a - bus.alu_b;
        m_cout = bus.alu_a < bus.alu_b;
        m_ovf  = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
      4'd2: m_res = bus.alu_a & bus.alu_b;
      4'd3: m_res = bus.alu_a | bus.alu_b;
      4'd4: m_res = bus.alu_a ^ bus.alu_b;
      4'd5: m_res = bus.alu_a << bus.alu_b[4:0];
      default: m_res = '0;
    endcase
  end

  assign bus.alu_result = m_res;
  assign bus.alu_zero   = (m_res == 32'd0);
  assign bus.alu_ovf    = m_ovf;
  assign bus.alu_cout   = m_cout;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_op[4*id +: 4]  = op;
  endtask

  // One isolated operation from requester id, response consumed immediately.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] eop, input logic [31:0] eres, input logic [3:0] eflg);
    logic [63:0] one_hot;
    one_hot = 64'd1 << id;
    @(negedge clk);
    set_req(id, a, b, op);
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    #1;
    check("grant", 64'(bus.req_ready), one_hot);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("issue_a", 64'(bus.alu_a), 64'(ea));
    check("issue_b", 64'(bus.alu_b), 64'(eb));
    check("issue_op", 64'(bus.alu_opcode), 64'(eop));
    check("issue_ready", 64'(bus.req_ready), 64'd0);
    check("issue_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_id", 64'(bus.rsp_id), 64'(id));
    check("rsp_result", 64'(bus.rsp_result), 64'(eres));
    check("rsp_flags", 64'(bus.rsp_flags), 64'(eflg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_result", 64'(bus.rsp_result), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations
    do_op(0, 32'd5, 32'd3, 4'd0, 32'd5, 32'd3, 4'd0, 32'd8, 4'b0000);
    do_op(1, 32'd7, 32'd7, 4'd1, 32'd7, 32'd7, 4'd1, 32'd0, 4'b0001);
    do_op(2, 32'h7FFF_FFFF, 32'd1, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd0,
          32'h8000_0000, 4'b0010);
    do_op(3, 32'h0000_00F0, 32'd5, 4'd5, 32'h0000_00F0, 32'd5, 4'd5,
          32'h0000_1E00, 4'b0000);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 4'b0101);
    do_op(1, 32'd123, 32'd456, 4'hA, 32'd0, 32'd0, 4'd0, 32'd0, 4'b1000);
    do_op(2, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd4,
          32'hF00F_F00F, 4'b0000);

    // ALU inputs hold their last issued values while idle
    @(negedge clk);
    #1;
    check("idle_hold_a", 64'(bus.alu_a), 64'hFF00_FF00);
    check("idle_hold_op", 64'(bus.alu_opcode), 64'd4);

    // Reset in the middle of an operation
    @(negedge clk);
    set_req(2, 32'd1, 32'd2, 4'd0);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    #1;
    check("mid_issue_a", 64'(bus.alu_a), 64'd1);
    for (int i = 0; i < 4; i++) set_req(i, 32'(10 * i), 32'd1, 4'd0);
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_id", 64'(bus.rsp_id), 64'd0);
    check("mid_rst_result", 64'(bus.rsp_result), 64'd0);
    check("mid_rst_flags", 64'(bus.rsp_flags), 64'd0);
    check("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("mid_rst_alu_b", 64'(bus.alu_b), 64'd0);
    check("mid_rst_alu_op", 64'(bus.alu_opcode), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters hold valid: grants 0,1,2,3,0 every third cycle
    for (int c = 0; c < 15; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check("rr_ready", 64'(bus.req_ready),
            (c % 3 == 0) ? (64'd1 << ((c / 3) % 4)) : 64'd0);
      check("rr_valid", 64'(bus.rsp_valid), (c % 3 == 2) ? 64'd1 : 64'd0);
      if (c % 3 == 2) begin
        check("rr_id", 64'(bus.rsp_id), 64'((c / 3) % 4));
        check("rr_result", 64'(bus.rsp_result), 64'(10 * ((c / 3) % 4) + 1));
      end
    end

    // Backpressure on the second response from requester 0
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_id", 64'(bus.rsp_id), 64'd0);
      check("bp_result", 64'(bus.rsp_result), 64'd1);
      check("bp_flags", 64'(bus.rsp_flags), 64'd0);
      check("bp_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_next_grant", 64'(bus.req_ready), 64'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("bp_next_issue", 64'(bus.alu_a), 64'd10);
    @(negedge clk);
    #1;
    check("bp_next_id", 64'(bus.rsp_id), 64'd1);
    check("bp_next_result", 64'(bus.rsp_result), 64'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Shares one combinational `ALU_32bit` instance between `NUM_REQ` requesters. Arbitration is round-robin. Each accepted operation is issued to the ALU from registered operands. The result and flags are captured and returned with a valid/ready response tagged with the requester ID. The block sits between the core's execution clients and the single ALU datapath; the ALU module itself is unchanged.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, `$clog2(NUM_REQ)`: requester-ID width (derived, not overridden).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_a`, `req_b`  in  NUM_REQ*32  packed operands; requester i occupies bits [32i+31:32i].
- `req_op`  in  NUM_REQ*4  packed opcodes; requester i occupies bits [4i+3:4i].
- `alu_a`, `alu_b`  out  32  operands to the ALU.
- `alu_opcode`  out  4  opcode to the ALU.
- `alu_result`  in  32  ALU result.
- `alu_zero`, `alu_ovf`, `alu_cout`  in  1  ALU zero, overflow and carry flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that issued the operation.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  4  {err, cout, ovf, zero}.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid` is high, grant requester g: the first set bit searching upward from `rr_ptr`, wrapping from NUM_REQ-1 to 0.
  - `req_ready[g]`=1 combinationally in that cycle; handshake = `req_valid[g]` & `req_ready[g]`.
  - On the handshake, register a/b/op/id, set `rr_ptr` <= (g+1) mod NUM_REQ, and go to ISSUE.
- **ISSUE**
  - `alu_a`/`alu_b`/`alu_opcode` are driven from the operand registers.
  - At the end of the cycle, capture `alu_result` and the three flags, then go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_*` stay stable until `rsp_ready`.
  - On `rsp_valid` & `rsp_ready`, go to IDLE.
  - `req_ready` is all-zero in ISSUE and RESP.
- **Legal opcodes:** 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL (shift amount is `B[4:0]`).
- **Opcodes 6..15 (illegal):**
  - The opcode is still accepted.
  - In ISSUE, `alu_opcode`=0 and operands are 0.
  - The response has `rsp_result`=0 and `rsp_flags`=4'b1000: err=1 and all ALU flags masked.
- **Requester behaviour:** a requester may drop `req_valid` before it is granted; the block keeps no state for it.
- **Idle outputs:** in IDLE the ALU inputs hold their last issued values; there is no toggling between operations.
- **Reset (`rst_n` low, any state, including mid-operation):**
  - State goes to IDLE and `rr_ptr` goes to 0.
  - Every output goes to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags`, `alu_a`, `alu_b`, `alu_opcode`.
  - An operation in flight is dropped and no response is produced.

## Timing
- Accept in cycle N; ALU is driven in N+1; `rsp_valid` rises in N+2.
- The response handshake in cycle M returns the FSM to IDLE in M+1, so the next accept is possible at M+1.
- Peak throughput: one operation per 3 cycles.
- Response backpressure has no upper bound; `rsp_*` must not change while `rsp_valid`=1 and `rsp_ready`=0.
- Simultaneous requests: exactly one grant per IDLE cycle. Losing requesters see `req_ready`=0 and must hold their request.
- A requester that wins is at the lowest priority for the next arbitration, so no requester waits for more than NUM_REQ-1 other grants.
- Reset deassertion: the first grant can occur on the first rising edge with `rst_n`=1.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e`: ADD=0 … SLL=5.
  - Constant `ALU_OP_LAST`=5.
  - `sched_state_e`: IDLE, ISSUE, RESP.
  - Flag bit-index constants.
- Sub-module `rr_arbiter`: parameterised NUM_REQ. It takes `req` and `ptr` and produces a one-hot `grant` plus the binary `grant_id`, combinationally.
- The top level holds the FSM, the pointer, the operand/result registers and the operand muxing.

## Test plan
- **Single ADD:** requester 0 sends a=5, b=3, op=0.
  - `req_ready[0]` is high in the same cycle.
  - `rsp_valid` rises 2 cycles later with `rsp_result`=8, flags=0000, `rsp_id`=0.
- **Zero and overflow:**
  - SUB 7,7 gives result 0 with zero=1.
  - ADD 0x7FFF_FFFF + 1 gives 0x8000_0000 with ovf=1.
  - SLL 0xF0 by 5 gives 0x1E00.
- **Round-robin:** all 4 requesters hold valid continuously with `rsp_ready`=1.
  - Grant order is 0,1,2,3,0.
  - Consecutive `rsp_valid` rising edges are exactly 3 cycles apart.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles.
  - `rsp_*` stay stable and `req_ready` stays all-zero.
  - When `rsp_ready` rises, the next grant occurs the following cycle.
- **Illegal opcode:** op=4'hA is accepted.
  - Response is `rsp_result`=0, flags=1000.
  - `alu_opcode` is 0 during ISSUE.
- **Reset mid-operation:** assert `rst_n`=0 during ISSUE.
  - All outputs read 0 immediately (asynchronous reset) and no response appears.
  - After release, requester 0 wins first.
